// File: rtl/level_monitor.sv
// Banded level monitor: debounced band commits with falling hysteresis,
// a sticky critical alarm and a sticky out-of-range flag.
module level_monitor #(
  parameter int WIDTH     = 5,
  parameter int MAX_LEVEL = 30,
  parameter int T_LOW     = 3,
  parameter int T_MED     = 6,
  parameter int T_HIGH    = 18,
  parameter int T_FULL    = 30,
  parameter int HYST      = 2,
  parameter int STABLE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sum,
  input  logic             sum_valid,
  input  logic             alarm_ack,
  output logic             critic_level,
  output logic             low_level,
  output logic             medium_level,
  output logic             high_level,
  output logic             full,
  output logic [2:0]       band_code,
  output logic             band_change,
  output logic             crit_alarm,
  output logic             range_err
);

  localparam int CW = (STABLE < 2) ? 1 : $clog2(STABLE + 1);

  typedef enum logic [2:0] {
    CRITIC = 3'd0,
    LOW    = 3'd1,
    MEDIUM = 3'd2,
    HIGH   = 3'd3,
    FULL   = 3'd4
  } band_e;

  // Falling thresholds are the next band's rising threshold minus HYST, floored at 0.
  localparam int FL_LOW_I  = (T_LOW  > HYST) ? (T_LOW  - HYST) : 0;
  localparam int FL_MED_I  = (T_MED  > HYST) ? (T_MED  - HYST) : 0;
  localparam int FL_HIGH_I = (T_HIGH > HYST) ? (T_HIGH - HYST) : 0;
  localparam int FL_FULL_I = (T_FULL > HYST) ? (T_FULL - HYST) : 0;

  localparam logic [WIDTH-1:0] MAX_V   = MAX_LEVEL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TH_LOW  = T_LOW[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TH_MED  = T_MED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TH_HIGH = T_HIGH[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TH_FULL = T_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FL_LOW  = FL_LOW_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FL_MED  = FL_MED_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FL_HIGH = FL_HIGH_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FL_FULL = FL_FULL_I[WIDTH-1:0];
  localparam logic [CW-1:0]    STABLE_C = STABLE[CW-1:0];

  function automatic band_e plain_band(input logic [WIDTH-1:0] s);
    band_e b;
    if (s > MAX_V)         b = FULL;
    else if (s >= TH_FULL) b = FULL;
    else if (s >= TH_HIGH) b = HIGH;
    else if (s >= TH_MED)  b = MEDIUM;
    else if (s >= TH_LOW)  b = LOW;
    else                   b = CRITIC;
    return b;
  endfunction

  band_e            band_q, band_d, prev_q, prev_d, cand_s, plain_s;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc_s;
  logic             first_q, first_d;
  logic             chg_q, chg_d;
  logic             crit_q, crit_d;
  logic             rerr_q, rerr_d;
  logic [4:0]       onehot_q, onehot_d;
  logic             commit_s;

  always_comb begin
    plain_s = plain_band(sum);
    if (plain_s > band_q)                      cand_s = plain_s;
    else if (band_q > CRITIC && sum < FL_LOW)  cand_s = CRITIC;
    else if (band_q > LOW    && sum < FL_MED)  cand_s = LOW;
    else if (band_q > MEDIUM && sum < FL_HIGH) cand_s = MEDIUM;
    else if (band_q > HIGH   && sum < FL_FULL) cand_s = HIGH;
    else                                       cand_s = band_q;
  end

  always_comb begin
    band_d    = band_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    commit_s  = 1'b0;
    cnt_inc_s = (cand_s == prev_q) ? (cnt_q + {{(CW-1){1'b0}}, 1'b1}) : {{(CW-1){1'b0}}, 1'b1};
    if (sum_valid) begin
      if (first_q) begin
        band_d   = plain_s;
        prev_d   = plain_s;
        cnt_d    = {CW{1'b0}};
        first_d  = 1'b0;
        commit_s = 1'b1;
      end else if (cand_s != band_q) begin
        prev_d = cand_s;
        if (cnt_inc_s >= STABLE_C) begin
          band_d   = cand_s;
          cnt_d    = {CW{1'b0}};
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end else begin
        prev_d = cand_s;
        cnt_d  = {CW{1'b0}};
      end
    end else begin
      cnt_d = cnt_q;
    end

    chg_d    = commit_s;
    onehot_d = 5'b00001 << band_d;

    // A commit into CRITIC beats a simultaneous acknowledge.
    if (commit_s && band_d == CRITIC)           crit_d = 1'b1;
    else if (alarm_ack && band_q != CRITIC)     crit_d = 1'b0;
    else                                        crit_d = crit_q;

    if (sum_valid && sum > MAX_V) rerr_d = 1'b1;
    else if (alarm_ack)           rerr_d = 1'b0;
    else                          rerr_d = rerr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      band_q   <= CRITIC;
      prev_q   <= CRITIC;
      cnt_q    <= {CW{1'b0}};
      first_q  <= 1'b1;
      chg_q    <= 1'b0;
      crit_q   <= 1'b0;
      rerr_q   <= 1'b0;
      onehot_q <= 5'b00001;
    end else begin
      band_q   <= band_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      chg_q    <= chg_d;
      crit_q   <= crit_d;
      rerr_q   <= rerr_d;
      onehot_q <= onehot_d;
    end
  end

  assign critic_level = onehot_q[0];
  assign low_level    = onehot_q[1];
  assign medium_level = onehot_q[2];
  assign high_level   = onehot_q[3];
  assign full         = onehot_q[4];
  assign band_code    = band_q;
  assign band_change  = chg_q;
  assign crit_alarm   = crit_q;
  assign range_err    = rerr_q;

endmodule

// File: tb/tb_level_monitor.sv
// Directed bench for level_monitor with default parameters; expected values
// are worked out by hand from the band thresholds and debounce rules.
module tb_level_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sum = 5'd0;
  logic       sum_valid = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       critic_level, low_level, medium_level, high_level, full;
  logic [2:0] band_code;
  logic       band_change, crit_alarm, range_err;

  int n_checks = 0;
  int n_pass   = 0;

  level_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .sum          (sum),
    .sum_valid    (sum_valid),
    .alarm_ack    (alarm_ack),
    .critic_level (critic_level),
    .low_level    (low_level),
    .medium_level (medium_level),
    .high_level   (high_level),
    .full         (full),
    .band_code    (band_code),
    .band_change  (band_change),
    .crit_alarm   (crit_alarm),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_band(input string tag, input int code);
    logic [4:0] oh;
    oh = 5'b00001 << code;
    check({tag, "_code"}, {29'd0, band_code}, code);
    check({tag, "_onehot"}, {27'd0, full, high_level, medium_level, low_level, critic_level}, {27'd0, oh});
  endtask

  // Apply one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic drive(input logic [4:0] s, input logic v, input logic ack);
    sum       = s;
    sum_valid = v;
    alarm_ack = ack;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_band("reset", 0);
    check("reset_chg", {31'd0, band_change}, 0);
    check("reset_crit", {31'd0, crit_alarm}, 0);
    check("reset_rerr", {31'd0, range_err}, 0);
    rst = 1'b0;

    // First valid sample commits directly.
    drive(5'd6, 1'b1, 1'b0);
    check_band("first", 2);
    check("first_chg", {31'd0, band_change}, 1);
    check("first_crit", {31'd0, crit_alarm}, 0);
    drive(5'd6, 1'b0, 1'b0);
    check("first_chg_drop", {31'd0, band_change}, 0);

    // Interrupted rise, then a clean three-sample rise.
    drive(5'd18, 1'b1, 1'b0);
    drive(5'd18, 1'b1, 1'b0);
    drive(5'd17, 1'b1, 1'b0);
    check_band("rise_broken", 2);
    drive(5'd18, 1'b1, 1'b0);
    drive(5'd18, 1'b1, 1'b0);
    check_band("rise_2of3", 2);
    drive(5'd18, 1'b1, 1'b0);
    check_band("rise_commit", 3);
    check("rise_chg", {31'd0, band_change}, 1);

    // Hysteresis: 17 and 16 hold HIGH; 15 falls, with gaps between samples.
    drive(5'd17, 1'b1, 1'b0);
    check("rise_chg_drop", {31'd0, band_change}, 0);
    drive(5'd16, 1'b1, 1'b0);
    check_band("hyst_16", 3);
    drive(5'd15, 1'b1, 1'b0);
    drive(5'd0, 1'b0, 1'b0);
    drive(5'd15, 1'b1, 1'b0);
    drive(5'd0, 1'b0, 1'b0);
    drive(5'd0, 1'b0, 1'b0);
    check_band("fall_gap", 3);
    drive(5'd15, 1'b1, 1'b0);
    check_band("fall_commit", 2);
    check("fall_chg", {31'd0, band_change}, 1);

    // Critical alarm and acknowledge rules.
    drive(5'd0, 1'b1, 1'b0);
    drive(5'd0, 1'b1, 1'b0);
    drive(5'd0, 1'b1, 1'b0);
    check_band("crit_commit", 0);
    check("crit_set", {31'd0, crit_alarm}, 1);
    drive(5'd0, 1'b0, 1'b1);
    check("crit_ack_in_critic", {31'd0, crit_alarm}, 1);
    drive(5'd6, 1'b1, 1'b0);
    drive(5'd6, 1'b1, 1'b0);
    drive(5'd6, 1'b1, 1'b0);
    check_band("crit_recover", 2);
    check("crit_held", {31'd0, crit_alarm}, 1);
    drive(5'd6, 1'b0, 1'b1);
    check("crit_ack", {31'd0, crit_alarm}, 0);

    // Out-of-range sample is a FULL candidate and sets the sticky flag.
    drive(5'd31, 1'b1, 1'b0);
    check("rerr_set", {31'd0, range_err}, 1);
    check_band("rerr_pending", 2);
    drive(5'd31, 1'b0, 1'b1);
    check("rerr_ack", {31'd0, range_err}, 0);
    drive(5'd31, 1'b1, 1'b1);
    check("rerr_set_wins", {31'd0, range_err}, 1);
    drive(5'd30, 1'b1, 1'b0);
    check_band("full_commit", 4);
    drive(5'd30, 1'b0, 1'b1);
    check("rerr_ack2", {31'd0, range_err}, 0);

    // Async reset in the middle of a 2-of-3 debounce.
    drive(5'd0, 1'b1, 1'b0);
    drive(5'd0, 1'b1, 1'b0);
    check_band("pre_rst", 4);
    sum_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_band("async_rst", 0);
    check("async_rst_chg", {31'd0, band_change}, 0);
    check("async_rst_rerr", {31'd0, range_err}, 0);
    #1 rst = 1'b0;
    drive(5'd20, 1'b1, 1'b0);
    check_band("post_rst_first", 3);
    check("post_rst_chg", {31'd0, band_change}, 1);
    check("post_rst_crit", {31'd0, crit_alarm}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
